// File: rtl/fft_result_streamer.sv
// fft_result_streamer: captures 8-point FFT core results, streams one bin per handshake.
// Define FFT_STREAM_BITREV_EN to emit bins in bit-reversed order.
module fft_result_streamer #(
   parameter int LATENCY = 4,
   parameter int W       = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           frame_start,
   input  logic [8*W-1:0] y_r_flat,
   input  logic [8*W-1:0] y_i_flat,
   input  logic           out_ready,
   input  logic           clr_overrun,
   output logic           out_valid,
   output logic [W-1:0]   out_r,
   output logic [W-1:0]   out_i,
   output logic [2:0]     out_idx,
   output logic           out_last,
   output logic           busy,
   output logic           overrun
);
   typedef enum logic {IDLE, SEND} state_t;

   state_t           state, state_n;
   logic [LATENCY-1:0] tok;
   logic [8*W-1:0]   buf_r, buf_i;
   logic [2:0]       pos, pos_n, bin_n;
   logic [W-1:0]     r_n, i_n;
   logic             tok_out, hs, done, cap, drop;

   assign tok_out   = tok[LATENCY-1];
   assign out_valid = (state == SEND);
   assign busy      = (state == SEND);
   assign hs        = out_valid & out_ready;
   assign done      = hs & out_last;
   assign cap       = tok_out & ((state == IDLE) | done);
   assign drop      = tok_out & ~cap;

   always_comb begin
      state_n = state;
      pos_n   = pos;
      if (cap) begin
         state_n = SEND;
         pos_n   = 3'd0;
      end else if (done) begin
         state_n = IDLE;
      end else if (hs) begin
         pos_n = pos + 3'd1;
      end
`ifdef FFT_STREAM_BITREV_EN
      bin_n = {pos_n[0], pos_n[1], pos_n[2]};
`else
      bin_n = pos_n;
`endif
      r_n = '0;
      i_n = '0;
      for (int k = 0; k < 8; k++) begin
         if (bin_n == 3'(k)) begin
            r_n = buf_r[k*W +: W];
            i_n = buf_i[k*W +: W];
         end
      end
      // a fresh capture bypasses the buffer so bin 0 is presented with no bubble
      if (cap) begin
         r_n = y_r_flat[W-1:0];
         i_n = y_i_flat[W-1:0];
      end
      if (state_n == IDLE) begin
         r_n = '0;
         i_n = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tok      <= '0;
         pos      <= '0;
         buf_r    <= '0;
         buf_i    <= '0;
         out_r    <= '0;
         out_i    <= '0;
         out_idx  <= '0;
         out_last <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_n;
         tok      <= LATENCY'({tok, frame_start});
         pos      <= pos_n;
         if (cap) begin
            buf_r <= y_r_flat;
            buf_i <= y_i_flat;
         end
         out_r    <= r_n;
         out_i    <= i_n;
         out_idx  <= (state_n == SEND) ? bin_n : 3'd0;
         out_last <= (state_n == SEND) && (bin_n == 3'd7);
         if (drop)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer: randomized bench with a queue-based frame/sample reference model.
`timescale 1ns/1ps
module tb_fft_result_streamer;
   localparam int LAT = 4;
   localparam int W   = 16;
   localparam int VW  = 7 + 2*W;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           frame_start = 1'b0;
   logic [8*W-1:0] y_r_flat = '0;
   logic [8*W-1:0] y_i_flat = '0;
   logic           out_ready = 1'b0;
   logic           clr_overrun = 1'b0;
   logic           out_valid;
   logic [W-1:0]   out_r, out_i;
   logic [2:0]     out_idx;
   logic           out_last, busy, overrun;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   int             tq_cyc[$];
   logic [8*W-1:0] tq_r[$], tq_i[$];
   logic [W-1:0]   eq_r[$], eq_i[$];
   logic [2:0]     eq_idx[$];
   bit             exp_ovr = 1'b0;

   fft_result_streamer #(.LATENCY(LAT), .W(W)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .y_r_flat(y_r_flat), .y_i_flat(y_i_flat),
      .out_ready(out_ready), .clr_overrun(clr_overrun),
      .out_valid(out_valid), .out_r(out_r), .out_i(out_i),
      .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic int bin_at(input int p);
`ifdef FFT_STREAM_BITREV_EN
      return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
`else
      return p;
`endif
   endfunction

   function automatic logic [8*W-1:0] rnd_frame();
      logic [8*W-1:0] f;
      for (int k = 0; k < 4; k++) f[k*32 +: 32] = $urandom;
      return f;
   endfunction

   function automatic logic [8*W-1:0] ramp(input logic [W-1:0] base);
      logic [8*W-1:0] f;
      for (int k = 0; k < 8; k++) f[k*W +: W] = base + W'(k);
      return f;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      if (eq_r.size() == 0)
         return {3'b000, exp_ovr, 3'd0, {(2*W){1'b0}}};
      return {1'b1, 1'b1, eq_r.size() == 1, exp_ovr,
              eq_idx[0], eq_r[0], eq_i[0]};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {out_valid, busy, out_last, overrun, out_idx, out_r, out_i};
   endfunction

   task automatic model_clear();
      tq_cyc.delete(); tq_r.delete(); tq_i.delete();
      eq_r.delete(); eq_i.delete(); eq_idx.delete();
      exp_ovr = 1'b0;
   endtask

   task automatic load(input logic [8*W-1:0] fr, input logic [8*W-1:0] fi);
      for (int p = 0; p < 8; p++) begin
         int b;
         b = bin_at(p);
         eq_r.push_back(fr[b*W +: W]);
         eq_i.push_back(fi[b*W +: W]);
         eq_idx.push_back(3'(b));
      end
   endtask

   // one clock cycle: drive inputs, advance the model, step to next cycle
   task automatic cycle(input bit fs, input bit rdy, input bit clr,
                        input logic [8*W-1:0] fr, input logic [8*W-1:0] fi);
      bit hs, drop;
      frame_start = fs;
      out_ready   = rdy;
      clr_overrun = clr;
      y_r_flat    = rnd_frame();
      y_i_flat    = rnd_frame();
      drop        = 1'b0;
      hs = (eq_r.size() > 0) && rdy;
      if (hs) begin
         void'(eq_r.pop_front());
         void'(eq_i.pop_front());
         void'(eq_idx.pop_front());
      end
      if (tq_cyc.size() > 0 && tq_cyc[0] == cyc) begin
         y_r_flat = tq_r[0];
         y_i_flat = tq_i[0];
         if (eq_r.size() == 0) load(tq_r[0], tq_i[0]);
         else drop = 1'b1;
         void'(tq_cyc.pop_front());
         void'(tq_r.pop_front());
         void'(tq_i.pop_front());
      end
      if (drop) exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      if (fs) begin
         tq_cyc.push_back(cyc + LAT);
         tq_r.push_back(fr);
         tq_i.push_back(fi);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      for (int n = 0; n < 40; n++) begin
         if (eq_r.size() == 0 && tq_cyc.size() == 0) break;
         cycle(1'b0, 1'b1, 1'b1, '0, '0);
      end
      cycle(1'b0, 1'b1, 1'b1, '0, '0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      frame_start = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         tests++;
         if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL reset_hold got %h want 0", dut_vec());
         end
      end
      frame_start = 1'b0;
      reset = 1'b0;
      cyc = 0;
      model_clear();
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_idle c%0d got %h want %h", cyc, dut_vec(), exp_vec());
         end
         cycle(1'b0, 1'b1, 1'b0, '0, '0);
      end
   endtask

   task automatic test_single();
      int s, first, n;
      s = cyc; first = -1; n = 0;
      cycle(1'b1, 1'b1, 1'b0, ramp(16'h0100), ramp(16'hF000));
      for (int i = 0; i < 14; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL single c%0d got %h want %h", cyc - s, dut_vec(), exp_vec());
         end
         if (out_valid) begin
            if (first < 0) first = cyc - s;
            n++;
         end
         cycle(1'b0, 1'b1, 1'b0, '0, '0);
      end
      tests++;
      if (first !== LAT + 1 || n !== 8) begin
         fails++;
         $display("FAIL single_timing first=%0d n=%0d want first=%0d n=8", first, n, LAT + 1);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int stall, n;
      bit rdy;
      stall = 0; n = 0;
      cycle(1'b1, 1'b1, 1'b0, ramp(16'h0100), ramp(16'hF000));
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL backpressure c%0d got %h want %h", cyc, dut_vec(), exp_vec());
         end
         rdy = !(eq_r.size() == 6 && stall < 3);
         if (!rdy) stall++;
         if (out_valid && rdy) n++;
         cycle(1'b0, rdy, 1'b0, '0, '0);
      end
      tests++;
      if (n !== 8 || stall !== 3) begin
         fails++;
         $display("FAIL backpressure_count got n=%0d stall=%0d want 8 3", n, stall);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int first, last, n;
      first = -1; last = -1; n = 0;
      for (int i = 0; i < 24; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL back_to_back c%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         if (out_valid) begin
            if (first < 0) first = i;
            last = i;
            n++;
         end
         cycle(i == 0 || i == 8, 1'b1, 1'b0,
               (i == 0) ? ramp(16'h0100) : ramp(16'h0200), ramp(16'hF000));
      end
      tests++;
      if (n !== 16 || last - first + 1 !== 16 || overrun !== 1'b0) begin
         fails++;
         $display("FAIL back_to_back_run got n=%0d span=%0d ovr=%b want 16 16 0",
                  n, last - first + 1, overrun);
      end
      drain();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL overrun c%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         cycle(i == 0 || i == 2, 1'b1, 1'b0, ramp(16'h0100), ramp(16'hF000));
      end
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_sticky got %b want 1", overrun);
      end
      cycle(1'b0, 1'b1, 1'b1, '0, '0);
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL overrun_clear got %b want 0", overrun);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      bit hit;
      hit = 1'b0;
      cycle(1'b1, 1'b1, 1'b0, ramp(16'h0100), ramp(16'hF000));
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_mid_pre c%0d got %h want %h", cyc, dut_vec(), exp_vec());
         end
         if (eq_r.size() == 5) begin
            hit = 1'b1;
            break;
         end
         cycle(1'b0, 1'b1, 1'b0, '0, '0);
      end
      tests++;
      if (!hit) begin
         fails++;
         $display("FAIL reset_mid_reach got idx=%0d want 3", out_idx);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (dut_vec() !== '0) begin
         fails++;
         $display("FAIL reset_mid_async got %h want 0", dut_vec());
      end
      model_clear();
      frame_start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_mid_post c%0d got %h want %h", i, dut_vec(), exp_vec());
         end
         cycle(1'b0, 1'b1, 1'b0, '0, '0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tests++;
         if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random c%0d got %h want %h", cyc, dut_vec(), exp_vec());
         end
         cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0, rnd_frame(), rnd_frame());
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Output-side companion to the 8-point pipelined FFT/IFFT core.
- Tracks frames issued into the core, captures the core's 8 parallel complex outputs when they emerge after the pipeline latency, and streams them out one complex sample per handshake (valid/ready).
- Sits between the FFT core outputs and the downstream serial consumer (I/O pin muxing or a memory writer).

Parameters:
- LATENCY, 4, cycles from the frame_start cycle to the cycle in which y_*_flat holds that frame's result; legal range 1..15.
- W, 16, bits per real/imag component.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  pulse; the FFT core is sampling a valid input frame this cycle.
- y_r_flat  input  8*W  core real outputs; word k at bits [k*W +: W].
- y_i_flat  input  8*W  core imaginary outputs, same packing.
- out_ready  input  1  downstream accepts the current sample.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- out_valid  output  1  out_r/out_i/out_idx/out_last are valid.
- out_r  output  W  real part of the current sample.
- out_i  output  W  imaginary part of the current sample.
- out_idx  output  3  frequency-bin index of the current sample.
- out_last  output  1  current sample is bin 7, the last of the frame.
- busy  output  1  buffer occupied (SEND state).
- overrun  output  1  sticky; a frame result was dropped.

Behaviour:
- Reset (async, immediate) values: out_valid=0, out_r=0, out_i=0, out_idx=0, out_last=0, busy=0, overrun=0, token shift register cleared, state IDLE.
- Token pipe: LATENCY-deep shift register shifts every cycle.
  - frame_start enters at stage 0.
  - The token exits in cycle T = start cycle + LATENCY, marking y_*_flat valid in cycle T.
  - Back-to-back frame_start pulses (every cycle) are supported; each one produces its own token.
- Capture: at the end of cycle T, all 16 words are registered into a 256-bit frame buffer if capture is allowed.
  - Capture is allowed when the state is IDLE, or when the state is SEND and the bin-7 handshake (out_valid & out_ready & out_last) completes in cycle T.
  - Otherwise the frame is dropped, the buffer is untouched and overrun is set.
- State IDLE: out_valid=0, busy=0. On capture go to SEND with idx=0.
- State SEND: out_valid=1, busy=1.
  - out_r/out_i = buffer word idx; out_idx = idx; out_last = (idx==7).
  - All outputs are registered and held stable while out_valid & !out_ready.
  - On handshake with idx<7: idx increments and the next word is presented the following cycle.
  - On handshake with idx==7: if a capture happens in the same cycle, stay in SEND with idx=0 and present the new frame next cycle (no bubble). Otherwise go to IDLE.
- Throughput: one sample per cycle with out_ready held high; 8 cycles per frame. Sustained frame_start every 8 cycles never overruns when out_ready=1.
- overrun: set on a drop, cleared by clr_overrun. Set has priority if both occur in the same cycle.
- Data is passed through unmodified; no arithmetic and no width change. out_r/out_i are zero while IDLE.
- Reset asserted mid-frame discards the buffer and all in-flight tokens; no sample from before reset is ever presented.
- out_valid does not depend combinationally on out_ready; there are no combinational input-to-output paths.

Optional Feature:
- Macro: FFT_STREAM_BITREV_EN.
- Defined: samples leave in bit-reversed bin order 0,4,2,6,1,5,3,7. out_idx reports the true bin number of each sample. out_last is asserted on the 8th sample of the frame (bin 7).
- Undefined: natural order 0..7 as described above.

Test Plan:
- Single frame: frame_start in cycle 0, y_r word k = 16'h0100+k, y_i word k = 16'hF000+k, out_ready=1 → out_valid in cycles 5..12; out_r 0x0100..0x0107; out_idx 0..7; out_last only in cycle 12.
- Backpressure: same frame, out_ready low for 3 cycles while idx=2 → out_r holds 0x0102 with out_valid=1 for 3 cycles, then the sequence resumes; total 8 samples, no duplicates.
- Back-to-back: frame_start at cycles 0 and 8 (frame B words 0x0200+k), out_ready=1 → 16 consecutive valid cycles 5..20, no bubble between 0x0107 and 0x0200; overrun stays 0.
- Overrun: frame_start at cycles 0 and 2 with out_ready=1 → frame A streams complete, frame B is dropped, overrun=1 from cycle 7; clr_overrun pulse → overrun=0 the next cycle.
- Reset mid-stream: assert reset while idx=3 → out_valid, busy and out_* go to 0 immediately; no further valid output after reset release without a new frame_start.
- FFT_STREAM_BITREV_EN defined: single frame as in the first test → out_idx sequence 0,4,2,6,1,5,3,7 with out_r 0x0100,0x0104,0x0102,0x0106,0x0101,0x0105,0x0103,0x0107; out_last on the final sample.
